// File: rtl/booth_r8_seq_ctrl.sv
// Sequential radix-8 Booth multiplier, 16x16 signed -> 32-bit signed product.
// One Booth digit per cycle over six ACC cycles; result held until the consumer takes it.
module booth_r8_seq_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] product,
  output logic        busy,
  output logic [2:0]  digit_idx
);

  // Handshake: a transfer happens on a rising edge where valid && ready;
  // in_ready is high only in IDLE, out_valid holds until out_ready in DONE.

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACC  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state;
  logic [15:0] a_q;
  logic [15:0] b_q;
  logic [33:0] acc;
  logic [2:0]  k;

  logic [18:0] b_ext;
  logic [4:0]  shamt;
  logic [3:0]  code;
  logic [18:0] a_x1, a_x2, a_x3, a_x4;
  logic [18:0] pp;
  logic [33:0] addend;
  logic [33:0] acc_next;

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign digit_idx = (state == ACC) ? k : 3'd0;

  // b_ext[j+1] holds B[j]; bit 0 is the implicit B[-1] = 0.
  assign b_ext = {b_q[15], b_q[15], b_q, 1'b0};
  assign shamt = ({2'b00, k} << 1) + {2'b00, k};

  always_comb begin
    code = 4'b0000;
    case (k)
      3'd0: code = b_ext[3:0];
      3'd1: code = b_ext[6:3];
      3'd2: code = b_ext[9:6];
      3'd3: code = b_ext[12:9];
      3'd4: code = b_ext[15:12];
      3'd5: code = b_ext[18:15];
      default: code = 4'b0000;
    endcase
  end

  // 19 bits so that -4 * -32768 = +131072 stays representable.
  assign a_x1 = {{3{a_q[15]}}, a_q};
  assign a_x2 = a_x1 << 1;
  assign a_x4 = a_x1 << 2;
  assign a_x3 = a_x1 + a_x2;

  always_comb begin
    pp = '0;
    case (code)
      4'b0001, 4'b0010: pp = a_x1;
      4'b0011, 4'b0100: pp = a_x2;
      4'b0101, 4'b0110: pp = a_x3;
      4'b0111:          pp = a_x4;
      4'b1000:          pp = -a_x4;
      4'b1001, 4'b1010: pp = -a_x3;
      4'b1011, 4'b1100: pp = -a_x2;
      4'b1101, 4'b1110: pp = -a_x1;
      default:          pp = '0;
    endcase
  end

  assign addend   = {{15{pp[18]}}, pp} << shamt;
  assign acc_next = acc + addend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      acc       <= '0;
      k         <= '0;
      product   <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= A;
            b_q   <= B;
            acc   <= '0;
            k     <= '0;
            state <= ACC;
          end
        end
        ACC: begin
          acc <= acc_next;
          if (k == 3'd5) begin
            k         <= '0;
            product   <= acc_next[31:0];
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            k <= k + 3'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
